// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a sign-extended immediate into the I/S/B/U fields of a base
// instruction word, flags values the format cannot hold, and queues results in a 2-entry buffer.
module imm_encoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMM_SRC_WIDTH = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [IMM_SRC_WIDTH-1:0] ImmSrc,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic [DATA_WIDTH-1:0]    BaseInstr,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_WIDTH-1:0]    Instr,
    output logic                     ImmErr,
    output logic [ERR_CNT_WIDTH-1:0] ErrCount
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [IMM_SRC_WIDTH-1:0] SRC_S = IMM_SRC_WIDTH'(1);
    localparam logic [IMM_SRC_WIDTH-1:0] SRC_B = IMM_SRC_WIDTH'(2);
    localparam logic [IMM_SRC_WIDTH-1:0] SRC_U = IMM_SRC_WIDTH'(3);

    logic [1:0]               state;
    logic [DATA_WIDTH-1:0]    head_instr, tail_instr;
    logic                     head_err, tail_err;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [DATA_WIDTH-1:0]    enc_instr;
    logic                     enc_err;
    logic                     push, pop;

    // NOTE: every output of an always_comb block is assigned a default first so no latch is inferred.
    always_comb begin
        enc_instr = BaseInstr;
        enc_err   = 1'b0;
        case (ImmSrc)
            SRC_S: begin
                enc_instr[31:25] = ImmOp[11:5];
                enc_instr[11:7]  = ImmOp[4:0];
                enc_err          = !((ImmOp[31:11] == '0) || (ImmOp[31:11] == '1));
            end
            SRC_B: begin
                enc_instr[31]    = ImmOp[12];
                enc_instr[30:25] = ImmOp[10:5];
                enc_instr[11:8]  = ImmOp[4:1];
                enc_instr[7]     = ImmOp[11];
                enc_err          = !((ImmOp[31:12] == '0) || (ImmOp[31:12] == '1)) || ImmOp[0];
            end
            SRC_U: begin
                enc_instr[31:12] = ImmOp[31:12];
                enc_err          = |ImmOp[11:0];
            end
            default: begin
                // I format; also covers any code a wider ImmSrc could carry.
                enc_instr[31:20] = ImmOp[11:0];
                enc_err          = !((ImmOp[31:11] == '0) || (ImmOp[31:11] == '1));
            end
        endcase
    end

    assign InReady  = (state != S_TWO) && rst_n;
    assign OutValid = (state != S_EMPTY);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;
    assign Instr    = head_instr;
    assign ImmErr   = head_err;
    assign ErrCount = err_count;

    // NOTE: the two buffer entries are plain registers, so they are reset; Instr must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            head_instr <= '0;
            head_err   <= 1'b0;
            tail_instr <= '0;
            tail_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        head_instr <= enc_instr;
                        head_err   <= enc_err;
                        state      <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && !pop) begin
                        tail_instr <= enc_instr;
                        tail_err   <= enc_err;
                        state      <= S_TWO;
                    end else if (pop && !push) begin
                        state <= S_EMPTY;
                    end else if (push && pop) begin
                        head_instr <= enc_instr;
                        head_err   <= enc_err;
                    end
                end
                S_TWO: begin
                    // InReady is low here, so only a pop can happen.
                    if (pop) begin
                        head_instr <= tail_instr;
                        head_err   <= tail_err;
                        state      <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase

            if (push && enc_err && (err_count != {ERR_CNT_WIDTH{1'b1}}))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: format encodings, error flagging, buffer ordering,
// error-counter saturation and reset while entries are queued.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [1:0]  ImmSrc;
    logic [31:0] ImmOp;
    logic [31:0] BaseInstr;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instr;
    logic        ImmErr;
    logic [7:0]  ErrCount;

    int tests_run    = 0;
    int tests_failed = 0;

    imm_encoder #(.DATA_WIDTH(32), .IMM_SRC_WIDTH(2), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .ImmSrc(ImmSrc), .ImmOp(ImmOp), .BaseInstr(BaseInstr),
        .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr),
        .ImmErr(ImmErr), .ErrCount(ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate generator (decoder side).
    function automatic logic [31:0] imm_dec(input logic [1:0] s, input logic [31:0] i);
        case (s)
            2'd1:    imm_dec = {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    imm_dec = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            2'd3:    imm_dec = {i[31:12], 12'b0};
            default: imm_dec = {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [1:0] s);
        case (s)
            2'd1, 2'd2: keep_mask = 32'h01FF_F07F;
            2'd3:       keep_mask = 32'h0000_0FFF;
            default:    keep_mask = 32'h000F_FFFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] base);
        ImmSrc    = s;
        ImmOp     = imm;
        BaseInstr = base;
        InValid   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        ImmSrc = 2'd0; ImmOp = '0; BaseInstr = '0;
        tick(); tick();
        tests_run++; if (InReady !== 1'b0) begin tests_failed++; $display("FAIL reset_inready got=%b want=0", InReady); end
        tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_outvalid got=%b want=0", OutValid); end
        tests_run++; if (Instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got=%h want=00000000", Instr); end
        tests_run++; if (ImmErr !== 1'b0) begin tests_failed++; $display("FAIL reset_immerr got=%b want=0", ImmErr); end
        tests_run++; if (ErrCount !== 8'h0) begin tests_failed++; $display("FAIL reset_errcount got=%h want=00", ErrCount); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (InReady !== 1'b1) begin tests_failed++; $display("FAIL reset_release_inready got=%b want=1", InReady); end
    endtask

    task automatic test_i_format();
        drive(2'd0, 32'hFFFF_F800, 32'h0000_0013);
        tick(); InValid = 1'b0;
        tests_run++; if (OutValid !== 1'b1) begin tests_failed++; $display("FAIL i_latency got=%b want=1", OutValid); end
        tests_run++; if (Instr !== 32'h8000_0013) begin tests_failed++; $display("FAIL i_instr got=%h want=80000013", Instr); end
        tests_run++; if (ImmErr !== 1'b0) begin tests_failed++; $display("FAIL i_immerr got=%b want=0", ImmErr); end
        tick();
        tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL i_drain got=%b want=0", OutValid); end
    endtask

    task automatic test_b_format();
        drive(2'd2, 32'h0000_0FFE, 32'h0000_0063);
        tick();
        tests_run++; if (Instr !== 32'h7E00_0FE3) begin tests_failed++; $display("FAIL b_instr got=%h want=7E000FE3", Instr); end
        tests_run++; if (ImmErr !== 1'b0) begin tests_failed++; $display("FAIL b_immerr got=%b want=0", ImmErr); end
        drive(2'd2, 32'h0000_0003, 32'h0000_0063);
        tick(); InValid = 1'b0;
        tests_run++; if (Instr !== 32'h0000_0163) begin tests_failed++; $display("FAIL b_odd_instr got=%h want=00000163", Instr); end
        tests_run++; if (ImmErr !== 1'b1) begin tests_failed++; $display("FAIL b_odd_immerr got=%b want=1", ImmErr); end
        tests_run++; if (ErrCount !== 8'd1) begin tests_failed++; $display("FAIL b_errcount got=%h want=01", ErrCount); end
        tick();
    endtask

    task automatic test_u_format();
        drive(2'd3, 32'h1234_5000, 32'h0000_0037);
        tick();
        tests_run++; if (Instr !== 32'h1234_5037) begin tests_failed++; $display("FAIL u_instr got=%h want=12345037", Instr); end
        tests_run++; if (ImmErr !== 1'b0) begin tests_failed++; $display("FAIL u_immerr got=%b want=0", ImmErr); end
        drive(2'd3, 32'h1234_5001, 32'h0000_0037);
        tick(); InValid = 1'b0;
        tests_run++; if (Instr !== 32'h1234_5037) begin tests_failed++; $display("FAIL u_low_instr got=%h want=12345037", Instr); end
        tests_run++; if (ImmErr !== 1'b1) begin tests_failed++; $display("FAIL u_low_immerr got=%b want=1", ImmErr); end
        tests_run++; if (ErrCount !== 8'd2) begin tests_failed++; $display("FAIL u_errcount got=%h want=02", ErrCount); end
        tick();
    endtask

    task automatic test_back_to_back();
        OutReady = 1'b0;
        drive(2'd0, 32'd1, 32'h0000_0013); tick();
        drive(2'd0, 32'd2, 32'h0000_0013); tick();
        drive(2'd0, 32'd3, 32'h0000_0013);
        tests_run++; if (InReady !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_inready got=%b want=0", InReady); end
        tests_run++; if (Instr !== 32'h0010_0013) begin tests_failed++; $display("FAIL b2b_head_a got=%h want=00100013", Instr); end
        tick();
        tests_run++; if (Instr !== 32'h0010_0013 || OutValid !== 1'b1) begin tests_failed++; $display("FAIL b2b_hold got=%h/%b want=00100013/1", Instr, OutValid); end
        OutReady = 1'b1;
        tick();
        tests_run++; if (Instr !== 32'h0020_0013) begin tests_failed++; $display("FAIL b2b_order_b got=%h want=00200013", Instr); end
        tests_run++; if (InReady !== 1'b1) begin tests_failed++; $display("FAIL b2b_reopen got=%b want=1", InReady); end
        tick(); InValid = 1'b0;
        tests_run++; if (Instr !== 32'h0030_0013) begin tests_failed++; $display("FAIL b2b_order_c got=%h want=00300013", Instr); end
        tick();
        tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got=%b want=0", OutValid); end
    endtask

    task automatic test_random();
        logic [1:0]  s;
        logic [31:0] imm, base, dec;
        for (int n = 0; n < 40; n++) begin
            s    = 2'($urandom_range(0, 3));
            base = $urandom;
            // Half the values are built to be representable, half are arbitrary.
            imm  = (n % 2 == 0) ? imm_dec(s, $urandom) : $urandom;
            drive(s, imm, base);
            tick(); InValid = 1'b0;
            dec = imm_dec(s, Instr);
            tests_run++;
            if (ImmErr !== (dec != imm)) begin
                tests_failed++;
                $display("FAIL rand_roundtrip src=%0d imm=%h got_err=%b redecoded=%h", s, imm, ImmErr, dec);
            end
            tests_run++;
            if ((Instr & keep_mask(s)) !== (base & keep_mask(s))) begin
                tests_failed++;
                $display("FAIL rand_basebits src=%0d got=%h want=%h", s, Instr & keep_mask(s), base & keep_mask(s));
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        OutReady = 1'b1;
        drive(2'd3, 32'h0000_0001, 32'h0000_0037);
        for (int n = 0; n < 254; n++) tick();
        tests_run++; if (ErrCount !== 8'hFE) begin tests_failed++; $display("FAIL sat_254 got=%h want=FE", ErrCount); end
        for (int n = 0; n < 46; n++) tick();
        InValid = 1'b0;
        tests_run++; if (ErrCount !== 8'hFF) begin tests_failed++; $display("FAIL sat_300 got=%h want=FF", ErrCount); end
        tick();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        OutReady = 1'b0;
        drive(2'd0, 32'h0000_1000, 32'h0000_0013); tick();
        drive(2'd0, 32'h0000_2000, 32'h0000_0013); tick();
        InValid = 1'b0;
        tests_run++; if (ErrCount !== 8'd2 || InReady !== 1'b0) begin tests_failed++; $display("FAIL mid_prefill got=%h/%b want=02/0", ErrCount, InReady); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (InReady !== 1'b0) begin tests_failed++; $display("FAIL mid_inready_low got=%b want=0", InReady); end
        tick();
        tests_run++; if (OutValid !== 1'b0 || ErrCount !== 8'd0 || Instr !== 32'h0) begin tests_failed++; $display("FAIL mid_reset got=%b/%h/%h want=0/00/00000000", OutValid, ErrCount, Instr); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin tests_failed++; $display("FAIL mid_release got=%b/%b want=1/0", InReady, OutValid); end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_b_format();
        test_u_format();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
